alu_dispatch: RTL
=================

// Module: alu_dispatch
// PURPOSE
// - Stage directly downstream of the ALU issue selector. Latches its one-hot issue0/issue1 grants.
// - Encodes each grant to a queue id and launches the op on ALU0/ALU1 with a one-cycle load strobe.
// - Tracks multi-cycle occupancy per ALU with a down-counter and signals completion.
// - Drives alu0_idle/alu1_idle back to the issue selector, closing the issue loop.
// PARAMETERS
// - IQ_ENTRIES  8  issue queue depth (width of one-hot vectors)
// - QIDW        3  queue id width, clog2(IQ_ENTRIES)
// - LAT_W       4  per-entry latency field width (cycles)
// - NUM_ALU     2  1 or 2; with 1, the ALU1 path is tied off
// PORTS
// - clk         in   1              clock
// - rst         in   1              synchronous active-high reset
// - ce          in   1              clock enable; all state holds when low
// - flush       in   1              branch-miss flush; abandons all in-flight ops
// - issue0      in   IQ_ENTRIES     one-hot grant for ALU0
// - issue1      in   IQ_ENTRIES     one-hot grant for ALU1
// - iq_lat      in   IQ_ENTRIES*LAT_W  latency of each queue entry; entry n is at [n*LAT_W +: LAT_W]
// - alu0_idle   out  1              ALU0 can accept a grant this cycle
// - alu1_idle   out  1              ALU1 can accept a grant this cycle
// - alu0_ld     out  1              ALU0 start strobe, one cycle
// - alu1_ld     out  1              ALU1 start strobe, one cycle
// - alu0_qid    out  QIDW           queue id of the op on ALU0
// - alu1_qid    out  QIDW           queue id of the op on ALU1
// - alu0_done   out  1              ALU0 completion strobe, one cycle; alu0_qid valid with it
// - alu1_done   out  1              ALU1 completion strobe, one cycle; alu1_qid valid with it
// - iq_out      out  IQ_ENTRIES     entries accepted last cycle; queue marks them out
// - issue_err   out  1              sticky protocol-error flag
// BEHAVIOUR
// - Single clock domain. Reset is synchronous and active-high.
// - Reset values:
//   - all ALUs IDLE; alu*_idle=1 (alu1_idle=0 when NUM_ALU==1)
//   - ld, done, iq_out, qid, issue_err all 0; counters 0
// - Per-ALU FSM, advancing only when ce=1:
//   - IDLE: grant nonzero -> BUSY; qid<=encode(grant); cnt<=max(lat,1); ld=1 next cycle
//   - BUSY: cnt decrements each cycle; when cnt==1 -> DONE
//   - DONE: done=1 for one cycle -> IDLE
// - Timing for a grant in cycle N:
//   - ld and qid valid in N+1
//   - BUSY for lat cycles, N+1..N+lat
//   - done in N+lat+1
//   - idle again in N+lat+2
// - iq_out is registered and equals the accepted grants of the previous cycle.
// - Latency arithmetic:
//   - lat=0 is treated as 1; the counter saturates and never wraps
//   - maximum occupancy is 2^LAT_W-1 busy cycles
// - Grant encode:
//   - lowest set bit wins
//   - more than one bit set -> issue_err<=1; op still launches on the lowest index
// - Grant while ALU not idle: ignored (no launch, no iq_out bit); issue_err<=1.
// - Same entry granted on both issue0 and issue1:
//   - ALU0 takes it; ALU1 ignores it; issue_err<=1
// - flush:
//   - all FSMs -> IDLE next cycle
//   - no done, ld or iq_out bits generated that cycle
//   - flush beats a simultaneous grant and a simultaneous DONE
// - ce=0:
//   - state, counters and qid hold
//   - ld and done forced 0; iq_out forced 0
// - rst has priority over flush and ce. Reset mid-operation drops the op with no done strobe.
// - issue_err clears only on rst.
// - NUM_ALU==1: issue1 is ignored; alu1_* outputs are constant 0.
// CONFIGURATION
// - ALU_EARLY_IDLE_EN defined:
//   - alu_idle is also 1 in DONE state
//   - a grant in DONE moves straight to BUSY, reloading qid and cnt
//   - done still pulses for the retiring op
//   - back-to-back ops then have one cycle less bubble
// - Not defined: alu_idle=1 only in IDLE, as specified above.
// TESTING
// - Reset then idle: alu0_idle=alu1_idle=1; all strobes 0; issue_err=0.
// - issue0=8'h04 with lat[2]=1 at cycle 0 -> alu0_ld, qid=2 and iq_out=8'h04 at 1; done at 2; idle at 3.
//   - With ALU_EARLY_IDLE_EN: idle at 2.
// - issue1=8'h10 with lat[4]=3 at cycle 0 -> alu1_ld at 1; busy 1..3; done at 4.
//   - A second issue1 in cycle 2 is ignored and sets issue_err.
// - issue0=issue1=8'h01 -> ALU0 launches qid 0; ALU1 stays idle; issue_err=1.
// - lat=5 op running; flush in cycle 3 -> idle in cycle 4; no done ever.
//   - A grant presented with flush is dropped.
// - ce held low for 4 cycles mid-BUSY -> done delayed exactly 4 cycles; no strobe while ce=0.

Source files
------------

// File: rtl/alu_dispatch.sv
// alu_dispatch: latches one-hot issue grants, launches ops on ALU0/ALU1 and tracks
// per-ALU occupancy with a saturating down-counter. Define ALU_EARLY_IDLE_EN to accept in DONE.
module alu_dispatch #(
    parameter int IQ_ENTRIES = 8,
    parameter int QIDW       = 3,
    parameter int LAT_W      = 4,
    parameter int NUM_ALU    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        flush,
    input  logic [IQ_ENTRIES-1:0]       issue0,
    input  logic [IQ_ENTRIES-1:0]       issue1,
    input  logic [IQ_ENTRIES*LAT_W-1:0] iq_lat,
    output logic                        alu0_idle,
    output logic                        alu1_idle,
    output logic                        alu0_ld,
    output logic                        alu1_ld,
    output logic [QIDW-1:0]             alu0_qid,
    output logic [QIDW-1:0]             alu1_qid,
    output logic                        alu0_done,
    output logic                        alu1_done,
    output logic [IQ_ENTRIES-1:0]       iq_out,
    output logic                        issue_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic ALU1_EN = (NUM_ALU > 1);

    function automatic logic [IQ_ENTRIES-1:0] lowest_bit(input logic [IQ_ENTRIES-1:0] g);
        return g & (~g + IQ_ENTRIES'(1));
    endfunction

    function automatic logic multi_hot(input logic [IQ_ENTRIES-1:0] g);
        return |(g & (g - IQ_ENTRIES'(1)));
    endfunction

    function automatic logic [QIDW-1:0] encode(input logic [IQ_ENTRIES-1:0] onehot);
        logic [QIDW-1:0] id;
        id = '0;
        for (int unsigned i = 0; i < IQ_ENTRIES; i++) begin
            if (onehot[i]) id = id | QIDW'(i);
        end
        return id;
    endfunction

    function automatic logic [LAT_W-1:0] load_count(input logic [IQ_ENTRIES*LAT_W-1:0] lat,
                                                    input logic [QIDW-1:0] id);
        logic [LAT_W-1:0] l;
        l = lat[int'(id)*LAT_W +: LAT_W];
        return (l == '0) ? LAT_W'(1) : l;
    endfunction

    logic [1:0]            st_q   [2];
    logic [1:0]            st_d   [2];
    logic [LAT_W-1:0]      cnt_q  [2];
    logic [LAT_W-1:0]      cnt_d  [2];
    logic [QIDW-1:0]       qid_q  [2];
    logic [QIDW-1:0]       qid_d  [2];
    logic [IQ_ENTRIES-1:0] acc    [2];
    logic [1:0]            ld_q;
    logic [1:0]            ld_d;
    logic [1:0]            idle;
    logic [IQ_ENTRIES-1:0] iq_out_q;
    logic [IQ_ENTRIES-1:0] iq_out_d;
    logic [IQ_ENTRIES-1:0] grant1;
    logic                  err_q;
    logic                  err_d;
    logic                  step;

    assign step   = ce & ~flush;
    assign grant1 = ALU1_EN ? issue1 : '0;

    always_comb begin
        for (int unsigned a = 0; a < 2; a++) begin
`ifdef ALU_EARLY_IDLE_EN
            idle[a] = (st_q[a] == ST_IDLE) || (st_q[a] == ST_DONE);
`else
            idle[a] = (st_q[a] == ST_IDLE);
`endif
        end
        idle[1] = idle[1] & ALU1_EN;
    end

    // ALU1 never sees an entry also granted to ALU0; the overlap only raises the error.
    always_comb begin
        acc[0] = idle[0] ? lowest_bit(issue0) : '0;
        acc[1] = idle[1] ? lowest_bit(grant1 & ~issue0) : '0;
        err_d  = err_q
               | multi_hot(issue0)
               | multi_hot(grant1)
               | (|(issue0 & grant1))
               | ((|issue0) & ~idle[0])
               | ((|grant1) & ~idle[1]);
    end

    always_comb begin
        ld_d     = '0;
        iq_out_d = acc[0] | acc[1];
        for (int unsigned a = 0; a < 2; a++) begin
            st_d[a]  = st_q[a];
            cnt_d[a] = cnt_q[a];
            qid_d[a] = qid_q[a];
            case (st_q[a])
                ST_BUSY: begin
                    cnt_d[a] = (cnt_q[a] == '0) ? '0 : cnt_q[a] - LAT_W'(1);
                    if (cnt_q[a] <= LAT_W'(1)) st_d[a] = ST_DONE;
                end
                ST_DONE: st_d[a] = ST_IDLE;
                default: st_d[a] = ST_IDLE;
            endcase
            if (|acc[a]) begin
                st_d[a]  = ST_BUSY;
                qid_d[a] = encode(acc[a]);
                cnt_d[a] = load_count(iq_lat, qid_d[a]);
                ld_d[a]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned a = 0; a < 2; a++) begin
                st_q[a]  <= ST_IDLE;
                cnt_q[a] <= '0;
                qid_q[a] <= '0;
            end
            ld_q     <= '0;
            iq_out_q <= '0;
            err_q    <= 1'b0;
        end else if (ce) begin
            if (flush) begin
                for (int unsigned a = 0; a < 2; a++) begin
                    st_q[a]  <= ST_IDLE;
                    cnt_q[a] <= '0;
                end
                ld_q     <= '0;
                iq_out_q <= '0;
            end else begin
                for (int unsigned a = 0; a < 2; a++) begin
                    st_q[a]  <= st_d[a];
                    cnt_q[a] <= cnt_d[a];
                    qid_q[a] <= qid_d[a];
                end
                ld_q     <= ld_d;
                iq_out_q <= iq_out_d;
                err_q    <= err_d;
            end
        end
    end

    // Strobes are suppressed in stalled and flushing cycles; the registers behind them hold.
    assign alu0_idle = idle[0];
    assign alu1_idle = idle[1];
    assign alu0_ld   = step & ld_q[0];
    assign alu1_ld   = step & ld_q[1];
    assign alu0_done = step & (st_q[0] == ST_DONE);
    assign alu1_done = step & (st_q[1] == ST_DONE);
    assign alu0_qid  = qid_q[0];
    assign alu1_qid  = qid_q[1];
    assign iq_out    = step ? iq_out_q : '0;
    assign issue_err = err_q;

endmodule
